// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan
// N:1 data selector with a registered output and a valid/ready handshake.
// Two operating modes:
//   manual - the channel comes from s; one capture per cycle while the
//            output slot is free.
//   scan   - round-robin over the channels enabled in ch_mask, spending
//            DWELL cycles on each channel before capturing it.
//
// Ports:
//   clk      clock, all state on the rising edge
//   rst      synchronous active-high reset
//   d        N*W channel data, channel i = d[i*W +: W]
//   s        manual-mode channel select
//   mode     0 = manual, 1 = scan
//   en       block enable (0 forces IDLE and drops any pending sample)
//   ch_mask  scan-mode channel enables, sampled live
//   y        registered selected data
//   y_ch     channel index that produced y
//   y_valid  y/y_ch hold an unconsumed sample
//   y_ready  consumer accepts the sample when y_valid && y_ready
module mux_nto1_scan #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       d,
  input  logic [$clog2(N)-1:0] s,
  input  logic                 mode,
  input  logic                 en,
  input  logic [N-1:0]         ch_mask,
  output logic [W-1:0]         y,
  output logic [$clog2(N)-1:0] y_ch,
  output logic                 y_valid,
  input  logic                 y_ready
);

  localparam int SW = $clog2(N);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          free;
  logic          cap;
  logic [SW-1:0] cap_ch;
  logic [W-1:0]  ch_data [N];

  for (genvar g = 0; g < N; g++) begin : g_split
    assign ch_data[g] = d[g*W +: W];
  end

  // Lowest set bit of the mask, 0 when the mask is empty.
  function automatic logic [SW-1:0] lowest_set(input logic [N-1:0] m);
    logic [SW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) r = SW'(i);
    end
    return r;
  endfunction

  // Next set bit strictly above p, wrapping; p itself if nothing else is set.
  // N is a power of two, so the SW-bit addition wraps naturally.
  function automatic logic [SW-1:0] next_set(input logic [N-1:0] m,
                                             input logic [SW-1:0] p);
    logic [SW-1:0] r;
    logic [SW-1:0] idx;
    logic          found;
    r     = p;
    found = 1'b0;
    for (int i = 1; i < N; i++) begin
      idx = p + SW'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign free = !y_valid || y_ready;

  always_comb begin
    state_d = IDLE;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    cap_ch  = s;

    if (en) state_d = mode ? SCAN : MANUAL;

    // Captures only happen when both this and the next cycle are in the same
    // mode, so a mode change never captures on the transition edge.
    if (state_d == SCAN && state_q != SCAN) begin
      ptr_d = lowest_set(ch_mask);
      cnt_d = CNT_RELOAD;
    end else if (state_d == SCAN && state_q == SCAN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (free) begin
        // A channel cleared mid-dwell is skipped but still advances ptr.
        cap    = ch_mask[ptr_q];
        cap_ch = ptr_q;
        ptr_d  = next_set(ch_mask, ptr_q);
        cnt_d  = CNT_RELOAD;
      end
    end else if (state_d == MANUAL && state_q == MANUAL) begin
      cap    = free;
      cap_ch = s;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        y       <= ch_data[cap_ch];
        y_ch    <= cap_ch;
        y_valid <= 1'b1;
      end else if (state_d == IDLE || free) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Testbench for mux_nto1_scan (N=8, W=8, DWELL=4).
// Expected captures (cycle, channel) are queued as stimulus is applied and
// compared when the corresponding edge has passed; cycles with no queued
// capture require y_valid=0 unless gap checking is switched off.
module tb_mux_nto1_scan;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int DWELL = 4;
  localparam int SW    = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] d;
  logic [SW-1:0]  s;
  logic           mode;
  logic           en;
  logic [N-1:0]   ch_mask;
  logic [W-1:0]   y;
  logic [SW-1:0]  y_ch;
  logic           y_valid;
  logic           y_ready;

  mux_nto1_scan #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .s       (s),
    .mode    (mode),
    .en      (en),
    .ch_mask (ch_mask),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    int ch;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  bit   chk_idle = 1'b1;
  int   e0;
  int   base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int at, input int ch);
    exp_t e;
    e.at = at;
    e.ch = ch;
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    if (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      chk("cap_valid", 32'(y_valid), 32'd1);
      chk("cap_ch",    32'(y_ch),    32'(e.ch));
      chk("cap_data",  32'(y),       32'(8'h10 + e.ch));
    end else if (chk_idle) begin
      chk("gap_valid", 32'(y_valid), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) d[i*W +: W] = 8'(8'h10 + i);
    rst     = 1'b1;
    en      = 1'b1;
    mode    = 1'b1;
    s       = '0;
    ch_mask = 8'hFF;
    y_ready = 1'b1;

    // Reset held for two edges, then the first edge after release.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_y",    32'(y),    32'd0);
      chk("rst_y_ch", 32'(y_ch), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("rel_y",    32'(y),    32'd0);
    chk("rel_y_ch", 32'(y_ch), 32'd0);
    en = 1'b0;
    tick();

    // Manual sweep.
    mode = 1'b0;
    en   = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      s = SW'(i);
      push(cyc + 1, i);
      tick();
      if (i == 5) chk("manual_s5", 32'(y), 32'h15);
    end
    en = 1'b0;
    tick();

    // Scan with full mask: 0..7 then wrap to 0.
    ch_mask = 8'hFF;
    mode    = 1'b1;
    en      = 1'b1;
    e0      = cyc + 1;
    for (int k = 0; k < 9; k++) push(e0 + DWELL * (k + 1), k % N);
    while (cyc < e0 + DWELL * 9) tick();
    en = 1'b0;
    tick();

    // Sparse mask with wrap, then clear bit 5 while dwelling on channel 5.
    ch_mask = 8'b1010_0100;
    en      = 1'b1;
    e0      = cyc + 1;
    push(e0 + 4, 2);
    push(e0 + 8, 5);
    push(e0 + 12, 7);
    push(e0 + 16, 2);
    while (cyc < e0 + 16) tick();
    base    = cyc;
    ch_mask = 8'b1000_0100;
    push(base + 8, 7);
    while (cyc < base + 8) tick();
    en = 1'b0;
    tick();

    // Backpressure after channel 3 is captured.
    ch_mask = 8'hFF;
    en      = 1'b1;
    e0      = cyc + 1;
    for (int k = 0; k < 4; k++) push(e0 + DWELL * (k + 1), k);
    while (cyc < e0 + 16) tick();
    y_ready  = 1'b0;
    chk_idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(y_valid), 32'd1);
      chk("bp_ch",    32'(y_ch),    32'd3);
      chk("bp_data",  32'(y),       32'h13);
    end
    y_ready  = 1'b1;
    chk_idle = 1'b1;
    push(cyc + 1, 4);
    push(cyc + 1 + DWELL, 5);
    base = cyc + 1 + DWELL;
    while (cyc < base) tick();

    // Drop en while a sample is pending and the consumer stalls.
    y_ready = 1'b0;
    en      = 1'b0;
    tick();
    chk("dis_valid", 32'(y_valid), 32'd0);
    chk("dis_hold_ch", 32'(y_ch), 32'd5);

    // Reset mid-dwell, then scan a single-channel mask.
    y_ready = 1'b1;
    en      = 1'b1;
    mode    = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_y",    32'(y),    32'd0);
    chk("midrst_y_ch", 32'(y_ch), 32'd0);
    rst     = 1'b0;
    ch_mask = 8'h40;
    e0      = cyc + 1;
    for (int k = 0; k < 3; k++) push(e0 + DWELL * (k + 1), 6);
    while (cyc < e0 + DWELL * 3) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nto1_scan.md
# mux_nto1_scan

Parametrised N:1 data selector with a registered output, a valid/ready output handshake and an automatic channel-scan mode. It generalises the combinational 8:1 mux to N channels of W bits. It adds two modes: a manual mode, where the channel comes from the select input, and a scan mode, where the block steps round-robin through a channel mask with a programmable dwell time. The block sits between a bank of sensor/data channels and a single downstream consumer.

## Interface
- N, 8: channel count; power of two, ≥2.
- W, 8: data width per channel.
- DWELL, 4: cycles spent on each channel in scan mode; ≥1.
- SW (localparam): $clog2(N).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  N*W  channel data; channel i is d[i*W +: W].
- s  input  SW  channel select, used in manual mode.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  block enable.
- ch_mask  input  N  scan-mode channel enables; bit i set = channel i visited.
- y  output  W  registered selected data.
- y_ch  output  SW  channel index that produced y.
- y_valid  output  1  y/y_ch hold an unconsumed sample.
- y_ready  input  1  consumer accepts the sample when y_valid && y_ready.

## Operation
- Reset: y=0, y_ch=0, y_valid=0, state IDLE, ptr=0, cnt=0. Reset has priority over every other input.
- Slot free: `free = !y_valid || y_ready`. A new capture is only allowed when the slot is free.
- Captures:
  - A capture loads y=d[ch], y_ch=ch, y_valid=1.
  - When the slot is free and no capture occurs, y_valid goes to 0 and y/y_ch hold their values.
- States: IDLE, MANUAL, SCAN. The next state is chosen every cycle:
  - en=0 gives IDLE.
  - en=1 with mode=0 gives MANUAL.
  - en=1 with mode=1 gives SCAN.
- IDLE:
  - No captures.
  - y_valid clears on the next edge; any pending sample is dropped.
  - y and y_ch hold.
- MANUAL: every cycle with the slot free, capture channel s.
- SCAN entry (from IDLE or MANUAL):
  - ptr = lowest set bit of ch_mask, or 0 if the mask is zero.
  - cnt = DWELL-1.
- SCAN, when cnt≠0: cnt decrements.
- SCAN, when cnt==0 and the slot is free:
  - If ch_mask[ptr]=1, capture channel ptr.
  - If ch_mask[ptr]=0, no capture occurs (the channel was cleared mid-dwell).
  - Either way, ptr advances to the next set mask bit above ptr, wrapping from N-1 to the lowest set bit, and cnt reloads DWELL-1.
  - If ptr is the only set bit, ptr stays where it is.
- SCAN, when cnt==0 and the slot is not free: stall. cnt stays 0, ptr holds, and the pending sample is not overwritten.
- ch_mask all zero in SCAN: no captures. ptr and cnt still cycle as defined, with ptr staying put.
- ch_mask is sampled live. Changes take effect at the next ptr advance or capture decision.
- Mode change while y_valid=1: the pending sample is kept until consumed; the new mode's first capture waits for the slot to be free.

## Timing
- MANUAL latency: d/s sampled at edge k appear on y/y_ch with y_valid=1 after edge k. With y_ready=1 continuously, throughput is one sample per cycle.
- SCAN latency: if the SCAN state is entered at edge e0, the first capture is at edge e0+DWELL.
- SCAN throughput: with y_ready=1, later captures occur every DWELL edges.
- DWELL=1: SCAN captures every cycle, and the next channel is selected each edge.
- Backpressure: y, y_ch and y_valid are stable while y_valid && !y_ready. No combinational path from y_ready to y or y_ch; the y_ready to y_valid path is registered only.
- The en falling edge takes effect in one cycle: y_valid=0 after the next edge, regardless of y_ready.
- rst asserted mid-scan: all outputs return to reset values after that edge. The next SCAN entry restarts at the lowest set mask bit.

## Test plan
Benches use N=8, W=8, DWELL=4.

- Reset: assert rst for 2 cycles with en=1, mode=1 → y=0, y_ch=0, y_valid=0 through reset and on the first edge after release.
- Manual sweep:
  - Stimulus: d[i]=8'h10+i; mode=0; y_ready=1; s stepped 0..7, one per cycle.
  - Required: each edge shows y=8'h10+s from the previous cycle, y_ch=s, y_valid=1.
  - Also check y=8'h15 for s=5.
- Scan, full mask:
  - Stimulus: ch_mask=8'hFF; enter SCAN at edge e0.
  - Required: captures of channels 0,1,…,7,0 at edges e0+4, e0+8, …, each with y_valid=1.
  - Required: y_valid=0 on the edges in between.
- Sparse mask and wrap:
  - Stimulus: ch_mask=8'b1010_0100.
  - Required: y_ch sequence 2,5,7,2.
  - Stimulus: clear bit 5 while dwelling on channel 5.
  - Required: no sample from channel 5; the next capture is channel 7 four cycles later.
- Backpressure:
  - Stimulus: in SCAN, hold y_ready=0 for 10 cycles after the capture of channel 3.
  - Required: y, y_ch=3 and y_valid=1 stable throughout; cnt stalls at 0.
  - Required: on y_ready=1, channel 3 is consumed and channel 4 is captured on that same edge.
- Disable and reset mid-operation:
  - Stimulus: drop en with y_valid=1 and y_ready=0.
  - Required: y_valid=0 after one edge.
  - Stimulus: pulse rst mid-dwell, then re-enter SCAN with ch_mask=8'h40.
  - Required: channel 6 is captured every 4 cycles.
